sel_scan_sequencer: RTL and testbench

SEL_SCAN_SEQUENCER -- requirements
Module: sel_scan_sequencer

---
 rtl/sel_scan_sequencer.sv | 147 ++++++++++++++
 tb/tb_sel_scan_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sel_scan_sequencer.sv
// sel_scan_sequencer
//   Steps a 3-bit channel select through the set bits of a channel mask.
//   Each visited channel is held for dwell+1 cycles. The select drives a
//   downstream 3-to-8 decoder. A scan runs once (mode=0) or repeats until
//   stopped (mode=1). Mask, dwell and mode are captured when the scan starts.
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begins a scan when idle (level, sampled every cycle)
//   stop       in   aborts an active scan
//   mode       in   0 = single pass, 1 = continuous
//   dwell      in   [DWELL_W-1:0] each channel is held for dwell+1 cycles
//   mask       in   [NCH-1:0] bit i set -> channel i is visited
//   sel        out  [2:0] active channel select
//   sel_valid  out  sel carries an active channel
//   busy       out  scan in progress
//   done       out  one-cycle pulse at the end of a single pass
//   err        out  one-cycle pulse when start is given with an empty mask
module sel_scan_sequencer #(
    parameter int DWELL_W = 8,
    parameter int NCH     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NCH-1:0]     mask,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_reg;
    logic [2:0]         sel_reg;
    logic               sel_valid_reg;
    logic               done_reg;
    logic               err_reg;
    logic [DWELL_W-1:0] dwell_cnt_reg;
    logic [DWELL_W-1:0] dwell_lat_reg;
    logic [NCH-1:0]     mask_lat_reg;
    logic               mode_lat_reg;

    // Latched-mask channels strictly above the current select.
    logic [NCH-1:0] above_next;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_above
            assign above_next[gi] = mask_lat_reg[gi] && (3'(gi) > sel_reg);
        end
    endgenerate

    // Lowest set bit of v; result is {found, index}.
    function automatic logic [3:0] lowest_set(input logic [NCH-1:0] v);
        logic [3:0] r;
        r = '0;
        // Descending walk so the last hit (the lowest index) wins.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    logic [3:0] first_next;   // lowest bit of the live mask input (scan start)
    logic [3:0] higher_next;  // next channel above current select
    logic [3:0] wrap_next;    // lowest bit of the latched mask (wrap-around)

    always_comb begin
        first_next  = lowest_set(mask);
        higher_next = lowest_set(above_next);
        wrap_next   = lowest_set(mask_lat_reg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            sel_reg       <= '0;
            sel_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            dwell_cnt_reg <= '0;
            dwell_lat_reg <= '0;
            mask_lat_reg  <= '0;
            mode_lat_reg  <= 1'b0;
        end else begin
            // Pulses last a single cycle unless re-asserted below.
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // start together with stop is ignored entirely.
                    if (start && !stop) begin
                        if (first_next[3]) begin
                            mask_lat_reg  <= mask;
                            dwell_lat_reg <= dwell;
                            mode_lat_reg  <= mode;
                            sel_reg       <= first_next[2:0];
                            sel_valid_reg <= 1'b1;
                            dwell_cnt_reg <= dwell;
                            state_reg     <= SCAN;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // stop outranks a same-cycle dwell expiry.
                    if (stop) begin
                        state_reg     <= IDLE;
                        sel_reg       <= '0;
                        sel_valid_reg <= 1'b0;
                        dwell_cnt_reg <= '0;
                    end else if (dwell_cnt_reg != '0) begin
                        dwell_cnt_reg <= dwell_cnt_reg - 1'b1;
                    end else if (higher_next[3]) begin
                        sel_reg       <= higher_next[2:0];
                        dwell_cnt_reg <= dwell_lat_reg;
                    end else if (mode_lat_reg && wrap_next[3]) begin
                        sel_reg       <= wrap_next[2:0];
                        dwell_cnt_reg <= dwell_lat_reg;
                    end else begin
                        state_reg     <= IDLE;
                        sel_reg       <= '0;
                        sel_valid_reg <= 1'b0;
                        done_reg      <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign sel       = sel_reg;
    assign sel_valid = sel_valid_reg;
    assign busy      = (state_reg == SCAN);
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_sel_scan_sequencer.sv
// tb_sel_scan_sequencer
//   Scoreboard bench for sel_scan_sequencer. Stimulus tasks push the expected
//   per-cycle channel visits, done and err events into a queue. A negedge
//   monitor pops and compares whenever the DUT shows sel_valid, done or err.
module tb_sel_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] dwell;
    logic [7:0] mask;
    logic [2:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    sel_scan_sequencer #(.DWELL_W(8), .NCH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .dwell     (dwell),
        .mask      (mask),
        .sel       (sel),
        .sel_valid (sel_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    localparam int K_VISIT = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        int kind;
        int sel;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic void push(input int k, input int s);
        exp_t e;
        e.kind = k;
        e.sel  = s;
        exp_q.push_back(e);
    endfunction

    // Single pass: every set bit in ascending order, dwell+1 cycles each, then done.
    function automatic void model_single(input logic [7:0] m, input int dw,
                                         output int first, output int ncyc);
        first = -1;
        ncyc  = 0;
        for (int c = 0; c < 8; c++) begin
            if (m[c]) begin
                if (first < 0) first = c;
                for (int r = 0; r <= dw; r++) push(K_VISIT, c);
                ncyc += dw + 1;
            end
        end
        push(K_DONE, 0);
    endfunction

    // Continuous: the k-th active cycle shows channel list[(k/(dw+1)) mod size].
    function automatic void model_cont(input logic [7:0] m, input int dw,
                                       input int n, output int first);
        int chans[$];
        for (int c = 0; c < 8; c++) if (m[c]) chans.push_back(c);
        first = chans[0];
        for (int k = 0; k < n; k++) push(K_VISIT, chans[(k / (dw + 1)) % chans.size()]);
    endfunction

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        int   act_kind;
        if (!rst) begin
            if (done || err) chk("done_err_exclusive", int'(done && err), 0);
            if (sel_valid || busy) chk("busy_vs_valid", int'(busy), int'(sel_valid));
            if (sel_valid || done || err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: sel_valid=%0d sel=%0d done=%0d err=%0d, expected no output",
                             sel_valid, sel, done, err);
                end else begin
                    e = exp_q.pop_front();
                    act_kind = sel_valid ? K_VISIT : (done ? K_DONE : K_ERR);
                    chk("event_kind", act_kind, e.kind);
                    if (e.kind == K_VISIT && act_kind == K_VISIT) chk("visit_sel", int'(sel), e.sel);
                    if (e.kind == K_DONE && act_kind == K_DONE) begin
                        chk("done_sel_zero", int'(sel), 0);
                        chk("done_busy_zero", int'(busy), 0);
                    end
                    if (e.kind == K_ERR && act_kind == K_ERR) chk("err_busy_zero", int'(busy), 0);
                end
            end
        end
    end

    task automatic scramble(input bit with_start);
        mask  = 8'($urandom);
        dwell = 8'($urandom_range(0, 5));
        mode  = 1'($urandom);
        if (with_start) start = 1'($urandom);
    endtask

    task automatic single_pass(input logic [7:0] m, input int dw, input bit mutate);
        int first, ncyc;
        @(posedge clk); #1;
        mask = m; dwell = 8'(dw); mode = 1'b0; start = 1'b1; stop = 1'b0;
        model_single(m, dw, first, ncyc);
        @(posedge clk); #1;
        start = 1'b0;
        chk("first_sel", int'(sel), first);
        chk("first_valid", int'(sel_valid), 1);
        repeat (ncyc) begin
            @(posedge clk); #1;
            if (mutate) scramble(1'b0);
        end
        #5;
        chk("pass_drained", exp_q.size(), 0);
        chk("pass_idle", int'(busy), 0);
    endtask

    task automatic continuous(input logic [7:0] m, input int dw, input int n, input bit mutate);
        int first;
        @(posedge clk); #1;
        mask = m; dwell = 8'(dw); mode = 1'b1; start = 1'b1; stop = 1'b0;
        model_cont(m, dw, n, first);
        @(posedge clk); #1;
        start = 1'b0;
        chk("cont_first_sel", int'(sel), first);
        chk("cont_first_valid", int'(sel_valid), 1);
        repeat (n - 1) begin
            @(posedge clk); #1;
            if (mutate) scramble(1'b1);
        end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0; start = 1'b0;
        chk("stop_sel", int'(sel), 0);
        chk("stop_valid", int'(sel_valid), 0);
        chk("stop_busy", int'(busy), 0);
        #5;
        chk("cont_drained", exp_q.size(), 0);
    endtask

    initial begin
        int first;
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; dwell = '0; mask = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sel", int'(sel), 0);
        chk("reset_valid", int'(sel_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        rst = 1'b0;

        single_pass(8'hFF, 2, 1'b0);
        continuous(8'b1010_0100, 0, 6, 1'b0);
        continuous(8'hFF, 3, 18, 1'b0);
        single_pass(8'hFF, 0, 1'b0);

        // Empty mask -> single err pulse.
        @(posedge clk); #1;
        mask = 8'h00; start = 1'b1; stop = 1'b0;
        push(K_ERR, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", int'(err), 1);
        chk("err_no_busy", int'(busy), 0);
        @(posedge clk); #1;
        chk("err_one_cycle", int'(err), 0);
        chk("err_drained", exp_q.size(), 0);

        // start with stop in idle -> nothing.
        @(posedge clk); #1;
        mask = 8'hFF; start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", int'(busy), 0);
        chk("startstop_err", int'(err), 0);
        chk("startstop_valid", int'(sel_valid), 0);

        // Inputs change during a full pass; the latched values must rule.
        single_pass(8'hFF, 1, 1'b1);

        // Asynchronous reset mid-scan while sel = 5.
        @(posedge clk); #1;
        mask = 8'hFF; dwell = 8'd1; mode = 1'b1; start = 1'b1; stop = 1'b0;
        model_cont(8'hFF, 1, 10, first);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_reset_sel", int'(sel), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_sel", int'(sel), 0);
        chk("async_rst_valid", int'(sel_valid), 0);
        chk("async_rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_drained", exp_q.size(), 0);
        single_pass(8'h80, 1, 1'b0);

        // Randomized scans with inputs scrambled while active.
        for (int it = 0; it < 10; it++) begin
            logic [7:0] m;
            int dw;
            m  = 8'($urandom_range(1, 255));
            dw = $urandom_range(0, 4);
            if ($urandom_range(0, 1) == 0) single_pass(m, dw, 1'b1);
            else continuous(m, dw, $urandom_range(1, 40), 1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("final_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
